// File: rtl/spi_inc_apply.sv
// spi_inc_apply: applies one SPI increment frame (length/width deltas) per
// rising edge of the receiver's done level. The level is synchronised into
// CLK, the increments are captured once, and then added to the live
// rectangle dimensions with clamping to [1, MAX].
//
// Configuration macro: INC_SIGNED_EN
//   defined   -> increments are two's-complement (-128..+127)
//   undefined -> increments are unsigned (0..255), add-only
//
// Timing: when edge k is the first edge to sample done_in=1, the
// increments are captured on edge k+SYNC_STAGES+1. The clamped sums are
// loaded into len_out/wid_out on edge k+SYNC_STAGES+2, and upd is high for
// the cycle that follows that edge. The FSM state named APPLY is that
// cycle, in which the new values are published.
module spi_inc_apply #(
  parameter int DIM_W       = 10,
  parameter int LEN_MAX     = 639,
  parameter int WID_MAX     = 479,
  parameter int LEN_INIT    = 64,
  parameter int WID_INIT    = 48,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             flag,
  input  logic             done_in,
  input  logic [7:0]       inc_length_in,
  input  logic [7:0]       inc_width_in,
  input  logic             clr,
  output logic [DIM_W-1:0] len_out,
  output logic [DIM_W-1:0] wid_out,
  output logic             upd,
  output logic             sat,
  output logic             busy
);

  // Two guard bits: one for the sign, one so that MAX + 255 cannot overflow.
  localparam int SUM_W = DIM_W + 2;

  localparam logic signed [SUM_W-1:0] LEN_MAX_S  = SUM_W'(LEN_MAX);
  localparam logic signed [SUM_W-1:0] WID_MAX_S  = SUM_W'(WID_MAX);
  localparam logic signed [SUM_W-1:0] ONE_S      = SUM_W'(1);
  localparam logic [DIM_W-1:0]        ONE_V      = DIM_W'(1);
  localparam logic [DIM_W-1:0]        LEN_INIT_V = DIM_W'(LEN_INIT);
  localparam logic [DIM_W-1:0]        WID_INIT_V = DIM_W'(WID_INIT);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAPT     = 3'd1,
    ST_CALC     = 3'd2,
    ST_APPLY    = 3'd3,
    ST_WAIT_LOW = 3'd4
  } state_t;

  // Widen an 8-bit increment to the sum width, signed or unsigned by build.
  function automatic logic signed [SUM_W-1:0] ext_inc(input logic [7:0] inc);
`ifdef INC_SIGNED_EN
    return {{(SUM_W-8){inc[7]}}, inc};
`else
    return {{(SUM_W-8){1'b0}}, inc};
`endif
  endfunction

  // Clamp a sum into [1, max_v]; the MSB of the result flags a clamp.
  function automatic logic [DIM_W:0] clamp_dim(input logic signed [SUM_W-1:0] sum,
                                               input logic signed [SUM_W-1:0] max_v);
    logic [DIM_W:0] res;
    if (sum > max_v) begin
      res = {1'b1, max_v[DIM_W-1:0]};
    end else if (sum < ONE_S) begin
      res = {1'b1, ONE_V};
    end else begin
      res = {1'b0, sum[DIM_W-1:0]};
    end
    return res;
  endfunction

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    d_prev_q, d_prev_d;
  logic [7:0]              inc_len_q, inc_len_d;
  logic [7:0]              inc_wid_q, inc_wid_d;
  logic [DIM_W-1:0]        len_q, len_d;
  logic [DIM_W-1:0]        wid_q, wid_d;
  logic                    upd_q, upd_d;
  logic                    sat_q, sat_d;

  logic                    d_s;
  logic signed [SUM_W-1:0] len_sum_s, wid_sum_s;
  logic [DIM_W:0]          len_clamp_s, wid_clamp_s;

  assign d_s = sync_q[SYNC_STAGES-1];

  // Synchroniser shift and done history for rising-edge detection.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], done_in};
    d_prev_d = d_s;
  end

  // FSM state, synchroniser and done history registers.
  always_ff @(posedge CLK or negedge flag) begin
    if (!flag) begin
      state_q  <= ST_IDLE;
      sync_q   <= '0;
      d_prev_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      d_prev_q <= d_prev_d;
    end
  end

  // Next-state logic: one pass per done rising edge, then wait for done low.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (d_s && !d_prev_q) begin
            state_d = ST_CAPT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CAPT:  state_d = ST_CALC;
        ST_CALC:  state_d = ST_APPLY;
        ST_APPLY: state_d = ST_WAIT_LOW;
        ST_WAIT_LOW: begin
          if (!d_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_LOW;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath: capture increments, form clamped sums, commit with upd pulse.
  always_comb begin
    inc_len_d   = inc_len_q;
    inc_wid_d   = inc_wid_q;
    len_d       = len_q;
    wid_d       = wid_q;
    sat_d       = sat_q;
    upd_d       = 1'b0;
    len_sum_s   = $signed({2'b00, len_q}) + ext_inc(inc_len_q);
    wid_sum_s   = $signed({2'b00, wid_q}) + ext_inc(inc_wid_q);
    len_clamp_s = clamp_dim(len_sum_s, LEN_MAX_S);
    wid_clamp_s = clamp_dim(wid_sum_s, WID_MAX_S);
    if (clr) begin
      len_d = LEN_INIT_V;
      wid_d = WID_INIT_V;
      sat_d = 1'b0;
    end else begin
      case (state_q)
        ST_CAPT: begin
          inc_len_d = inc_length_in;
          inc_wid_d = inc_width_in;
        end
        ST_CALC: begin
          len_d = len_clamp_s[DIM_W-1:0];
          wid_d = wid_clamp_s[DIM_W-1:0];
          sat_d = sat_q | len_clamp_s[DIM_W] | wid_clamp_s[DIM_W];
          upd_d = 1'b1;
        end
        default: begin
          upd_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath registers; reset aborts any update in flight.
  always_ff @(posedge CLK or negedge flag) begin
    if (!flag) begin
      inc_len_q <= 8'h00;
      inc_wid_q <= 8'h00;
      len_q     <= LEN_INIT_V;
      wid_q     <= WID_INIT_V;
      upd_q     <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      inc_len_q <= inc_len_d;
      inc_wid_q <= inc_wid_d;
      len_q     <= len_d;
      wid_q     <= wid_d;
      upd_q     <= upd_d;
      sat_q     <= sat_d;
    end
  end

  // Outputs: registered values, busy decoded from the registered state.
  always_comb begin
    len_out = len_q;
    wid_out = wid_q;
    upd     = upd_q;
    sat     = sat_q;
    busy    = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_spi_inc_apply.sv
// Self-checking bench for spi_inc_apply. A frame-level model predicts
// len/wid/upd/sat every cycle; directed scenarios add literal checks.
module tb_spi_inc_apply;

  localparam int LAT = 4;  // first done sample edge k -> upd after edge k+LAT

  logic       CLK = 1'b0;
  logic       flag = 1'b0;
  logic       done_in = 1'b0;
  logic [7:0] inc_length_in = 8'h00;
  logic [7:0] inc_width_in = 8'h00;
  logic       clr = 1'b0;
  logic [9:0] len_out, wid_out;
  logic       upd, sat, busy;

  int checks = 0;
  int errors = 0;

  spi_inc_apply dut (
    .CLK(CLK), .flag(flag), .done_in(done_in),
    .inc_length_in(inc_length_in), .inc_width_in(inc_width_in),
    .clr(clr), .len_out(len_out), .wid_out(wid_out),
    .upd(upd), .sat(sat), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  int m_len = 64, m_wid = 48, m_cyc = 0, m_at = 0, m_il = 0, m_iw = 0;
  bit m_upd = 1'b0, m_sat = 1'b0, m_pend = 1'b0, m_armed = 1'b1;

  function automatic int inc_val(input logic [7:0] v);
`ifdef INC_SIGNED_EN
    return int'($signed(v));
`else
    return int'(v);
`endif
  endfunction

  always @(posedge CLK or negedge flag) begin
    if (!flag) begin
      m_len = 64; m_wid = 48; m_sat = 1'b0; m_upd = 1'b0;
      m_pend = 1'b0; m_armed = 1'b1;
    end else begin
      int s;
      m_cyc++;
      m_upd = 1'b0;
      if (clr) begin
        m_len = 64; m_wid = 48; m_sat = 1'b0; m_pend = 1'b0;
      end else if (m_pend && m_cyc == m_at) begin
        s = m_len + m_il;
        if (s > 639) begin s = 639; m_sat = 1'b1; end
        else if (s < 1) begin s = 1; m_sat = 1'b1; end
        m_len = s;
        s = m_wid + m_iw;
        if (s > 479) begin s = 479; m_sat = 1'b1; end
        else if (s < 1) begin s = 1; m_sat = 1'b1; end
        m_wid = s;
        m_upd = 1'b1;
        m_pend = 1'b0;
      end
      if (done_in && m_armed && !m_pend) begin
        m_pend = 1'b1; m_at = m_cyc + LAT;
        m_il = inc_val(inc_length_in); m_iw = inc_val(inc_width_in);
        m_armed = 1'b0;
      end else if (!done_in) begin
        m_armed = 1'b1;
      end
    end
  end

  // Compare DUT against the model one time unit after every rising edge.
  always @(posedge CLK) begin
    #1;
    chk("len_out", int'(len_out), m_len);
    chk("wid_out", int'(wid_out), m_wid);
    chk("upd", int'(upd), int'(m_upd));
    chk("sat", int'(sat), int'(m_sat));
  end

  // ---------------- directed stimulus ----------------
  task automatic run_frame(input logic [7:0] li, input logic [7:0] wi, input int hold,
                           output int upd_cnt, output int upd_edge, output int busy_mid);
    @(negedge CLK);
    inc_length_in = li; inc_width_in = wi; done_in = 1'b1;
    upd_cnt = 0; upd_edge = 0; busy_mid = 0;
    for (int n = 1; n <= hold; n++) begin
      @(posedge CLK); #1;
      if (n == 3) busy_mid = int'(busy);
      if (upd) begin
        upd_cnt++;
        if (upd_edge == 0) upd_edge = n;
      end
    end
    @(negedge CLK); done_in = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic pulse_clr();
    @(negedge CLK); clr = 1'b1;
    @(negedge CLK); clr = 1'b0;
  endtask

  task automatic count_upd(input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge CLK); #1;
      if (upd) cnt++;
    end
  endtask

  initial begin
    int uc, ue, bm;
    // 1: reset
    repeat (3) @(negedge CLK);
    flag = 1'b1;
    @(negedge CLK);
    chk("rst_len", int'(len_out), 64);
    chk("rst_wid", int'(wid_out), 48);
    chk("rst_upd", int'(upd), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_busy", int'(busy), 0);

    // 2: basic frame, upd exactly at edge 5
    run_frame(8'h10, 8'h08, 8, uc, ue, bm);
    chk("t2_upd_edge", ue, 5);
    chk("t2_upd_cnt", uc, 1);
    chk("t2_busy_mid", bm, 1);
    chk("t2_len", int'(len_out), 80);
    chk("t2_wid", int'(wid_out), 56);
    chk("t2_sat", int'(sat), 0);
    chk("t2_busy_end", int'(busy), 0);

    // 4: done held 100 cycles -> one update; second rise -> second update
    run_frame(8'h01, 8'h02, 100, uc, ue, bm);
    chk("t4_upd_cnt", uc, 1);
    chk("t4_len", int'(len_out), 81);
    chk("t4_wid", int'(wid_out), 58);
    run_frame(8'h01, 8'h02, 8, uc, ue, bm);
    chk("t4b_upd_cnt", uc, 1);
    chk("t4b_len", int'(len_out), 82);
    chk("t4b_wid", int'(wid_out), 60);

    // 3: clamping
    pulse_clr();
    chk("clr_len", int'(len_out), 64);
    chk("clr_wid", int'(wid_out), 48);
`ifdef INC_SIGNED_EN
    run_frame(8'h80, 8'h00, 8, uc, ue, bm);
    chk("t3s_len", int'(len_out), 1);
    chk("t3s_sat", int'(sat), 1);
    pulse_clr();
    run_frame(8'h00, 8'h80, 8, uc, ue, bm);
    chk("t3s_wid", int'(wid_out), 1);
    chk("t3s_wsat", int'(sat), 1);
`else
    run_frame(8'hFF, 8'h00, 8, uc, ue, bm);
    chk("t3_len319", int'(len_out), 319);
    run_frame(8'hFF, 8'h00, 8, uc, ue, bm);
    run_frame(8'h1A, 8'h00, 8, uc, ue, bm);
    chk("t3_len600", int'(len_out), 600);
    chk("t3_sat0", int'(sat), 0);
    run_frame(8'h64, 8'h00, 8, uc, ue, bm);
    chk("t3_len_clamp", int'(len_out), 639);
    chk("t3_sat1", int'(sat), 1);
    pulse_clr();
    chk("t3_clr_sat", int'(sat), 0);
    run_frame(8'h00, 8'hFF, 8, uc, ue, bm);
    run_frame(8'h00, 8'hFF, 8, uc, ue, bm);
    chk("t3_wid_clamp", int'(wid_out), 479);
    chk("t3_len_keep", int'(len_out), 64);
    chk("t3_wsat", int'(sat), 1);
`endif

    // 5: clr on the commit cycle wins
    @(negedge CLK);
    inc_length_in = 8'h10; inc_width_in = 8'h10; done_in = 1'b1;
    repeat (4) @(posedge CLK);
    @(negedge CLK); clr = 1'b1;
    @(posedge CLK); #1;
    chk("t5_upd", int'(upd), 0);
    chk("t5_len", int'(len_out), 64);
    chk("t5_wid", int'(wid_out), 48);
    chk("t5_sat", int'(sat), 0);
    chk("t5_busy", int'(busy), 0);
    @(negedge CLK); clr = 1'b0;
    count_upd(8, uc);
    chk("t5_no_upd", uc, 0);
    @(negedge CLK); done_in = 1'b0;
    repeat (6) @(negedge CLK);

    // 6: reset during CALC aborts the update
    run_frame(8'h20, 8'h20, 8, uc, ue, bm);
    chk("t6_pre_len", int'(len_out), 96);
    chk("t6_pre_wid", int'(wid_out), 80);
    @(negedge CLK);
    inc_length_in = 8'h05; inc_width_in = 8'h05; done_in = 1'b1;
    repeat (4) @(posedge CLK);
    @(negedge CLK); flag = 1'b0;
    #1;
    chk("t6_rst_len", int'(len_out), 64);
    chk("t6_rst_wid", int'(wid_out), 48);
    chk("t6_rst_upd", int'(upd), 0);
    chk("t6_rst_busy", int'(busy), 0);
    done_in = 1'b0;
    repeat (3) @(negedge CLK);
    flag = 1'b1;
    count_upd(10, uc);
    chk("t6_no_upd", uc, 0);
    run_frame(8'h05, 8'h05, 8, uc, ue, bm);
    chk("t6_upd_edge", ue, 5);
    chk("t6_len", int'(len_out), 69);
    chk("t6_wid", int'(wid_out), 53);

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
